uart_rx_sampler: RTL
====================

// Module: uart_rx_sampler
//
// PURPOSE
//  UART receive front end. Sits directly downstream of the 16x baud-tick generator.
//  Consumes its single-cycle baudTick strobe and oversamples the serial rx line.
//  Recovers 8N1-style frames (start, DATA_WIDTH bits LSB first, one stop bit).
//  Presents each byte on a valid/ready handshake; flags framing and overrun errors.
//
// PARAMETERS
//  DATA_WIDTH   8    data bits per frame
//  OVERSAMPLE   16   baudTick strobes per bit period (must be even, >=4)
//  SYNC_STAGES  2    flops in the rx input synchroniser (>=2)
//
// PORTS
//  clk        input   1           system clock
//  rstN       input   1           reset; asynchronous, active-low
//  baudTick   input   1           1-cycle strobe, OVERSAMPLE per bit period
//  rx         input   1           asynchronous serial line, idle high
//  rxData     output  DATA_WIDTH  received byte, stable while rxValid=1
//  rxValid    output  1           byte available
//  rxReady    input   1           consumer accepts byte when rxValid&rxReady
//  frameErr   output  1           1-cycle pulse: stop bit sampled low
//  overrun    output  1           1-cycle pulse: completed byte dropped
//  busy       output  1           high in any state other than IDLE
//
// BEHAVIOUR
//  Reset (rstN=0, async):
//  - Synchroniser flops reset to 1.
//  - State=IDLE; tick and bit counters reset to 0.
//  - rxData=0, rxValid=0, frameErr=0, overrun=0, busy=0.
//  - Asserting reset mid-frame abandons the frame entirely; no partial data or flags are produced.
//  Advance rule:
//  - Tick counter (width $clog2(OVERSAMPLE)) and the FSM advance only on cycles with baudTick=1.
//  - All decisions use the synchronised rx (rxS).
//  FSM:
//  - IDLE: on baudTick with rxS=0, go to START with tick=0.
//  - START: at tick==OVERSAMPLE/2-1 (mid-bit), sample rxS.
//    - rxS=0: go to DATA with tick=0, bit=0.
//    - rxS=1: glitch; go to IDLE with no flags.
//  - DATA: at tick==OVERSAMPLE-1, shift rxS into shift[DATA_WIDTH-1] (right shift, LSB first).
//    - Then tick=0 and bit++.
//    - After bit==DATA_WIDTH-1 is sampled, go to STOP.
//  - STOP: at tick==OVERSAMPLE-1, sample rxS, then go to IDLE.
//    - rxS=1: byte complete, handled by the output stage.
//    - rxS=0: frameErr=1 for exactly one clk; byte discarded.
//  - Tick counter wraps to 0 after OVERSAMPLE-1.
//  Output stage (registered):
//  - rxValid/rxData update on the clk edge after the completing baudTick cycle, so latency from the stop sample is 1 clk.
//  - Transfer occurs when rxValid&rxReady; on transfer, rxValid drops next cycle unless a new byte completes.
//  - Completion with rxValid=0: load rxData, set rxValid=1.
//  - Completion with rxValid=1 and rxReady=1 in the same cycle: load the new byte, keep rxValid=1.
//  - Completion with rxValid=1 and rxReady=0: keep the old rxData, drop the new byte, overrun=1 for one clk.
//  - rxData must not change while rxValid=1 && rxReady=0.
//  - rxReady while rxValid=0 has no effect.
//
// TESTING
//  Directed cases, baudTick driven every 4 clk, OVERSAMPLE=16:
//  - Frame 0xA5, rxReady=1 -> rxValid high 1 clk after the stop sample, rxData=0xA5; frameErr=0, overrun=0.
//  - rx low for 3 ticks then high (glitch) -> return to IDLE; rxValid, frameErr and busy all low after ~8 ticks.
//  - Frame 0x3C with stop bit=0 -> exactly one frameErr pulse; rxValid stays 0; the next good 0x3C frame is received.
//  - Frames 0x11 then 0x22 back-to-back, rxReady=0 -> rxData=0x11 held; one overrun pulse at 0x22 stop; rxReady=1 then reads 0x11.
//  - rxReady pulses in the exact cycle 0x22 completes while 0x11 is valid -> rxData=0x22, rxValid stays 1, no overrun.
//  - rstN low during data bit 4 of 0xFF -> all outputs 0 immediately; after release, frame 0x5A gives rxData=0x5A.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//
// Purpose:
//    UART receive front end. It oversamples the asynchronous rx line on each
//    baudTick strobe coming from the 16x baud generator. It recovers frames
//    made of a start bit, DATA_WIDTH data bits sent LSB first, and one stop bit.
//    Each received byte is presented on a valid/ready handshake. Framing errors
//    and overruns are reported as single-cycle pulses.
//
// Ports:
//    clk       system clock
//    rstN      asynchronous, active-low reset
//    baudTick  1-cycle strobe, OVERSAMPLE strobes per bit period
//    rx        asynchronous serial line, idle high
//    rxData    received byte, held stable while rxValid is high
//    rxValid   byte available
//    rxReady   consumer takes the byte when rxValid & rxReady
//    frameErr  1-cycle pulse: the stop bit was sampled low
//    overrun   1-cycle pulse: a completed byte was dropped
//    busy      high whenever the receiver is not idle
`timescale 1ns/1ps

module uart_rx_sampler #(
   parameter int DATA_WIDTH  = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  baudTick,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] rxData,
   output logic                  rxValid,
   input  logic                  rxReady,
   output logic                  frameErr,
   output logic                  overrun,
   output logic                  busy
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rx_s;
   state_t                 state_q, state_d;
   logic [TICK_W-1:0]      tick_q, tick_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d;
   logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic                   byte_done;

   // The raw line is shifted through the synchroniser chain. All receiver
   // decisions use the last stage, rx_s, and never the raw pin.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], rx};
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   // Framing FSM and its counters. Nothing moves except on a baudTick cycle.
   // The start bit is confirmed at its midpoint (OVERSAMPLE/2 ticks in). After
   // that, every later sample lands a full bit period apart, near the centre of
   // each data bit and of the stop bit.
   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      byte_done   = 1'b0;
      frame_err_d = 1'b0;
      if (baudTick) begin
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  tick_d  = '0;
               end
            end
            START: begin
               if (tick_q == TICK_MID) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = rx_s ? IDLE : DATA;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            DATA: begin
               if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  // The concatenation is one bit wider than the shifter, so
                  // this right shift also works when DATA_WIDTH is 1.
                  shift_d = DATA_WIDTH'({rx_s, shift_q} >> 1);
                  if (bit_q == BIT_LAST) begin
                     bit_d   = '0;
                     state_d = STOP;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            STOP: begin
               if (tick_q == TICK_LAST) begin
                  tick_d      = '0;
                  state_d     = IDLE;
                  byte_done   = rx_s;
                  frame_err_d = !rx_s;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               tick_d  = '0;
               bit_d   = '0;
            end
         endcase
      end
   end

   // Output handshake. A byte that completes while the previous byte is still
   // pending gets through only if the consumer takes the old byte in that same
   // cycle. Otherwise the new byte is dropped and overrun pulses, so rxData
   // never changes under a stalled consumer.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = 1'b0;
      if (byte_done) begin
         if (!rx_valid_q || rxReady) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rx_valid_q && rxReady) begin
         rx_valid_d = 1'b0;
      end
   end

   // State register. Reset fills the synchroniser with the idle-high level, so
   // leaving reset never looks like a start bit.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sync_q      <= '1;
         state_q     <= IDLE;
         tick_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rxData   = rx_data_q;
   assign rxValid  = rx_valid_q;
   assign frameErr = frame_err_q;
   assign overrun  = overrun_q;
   assign busy     = (state_q != IDLE);

endmodule
